// File: rtl/audio_sample_scheduler.sv
// audio_sample_scheduler
// Buffers up to SAMPLES_PER_PACKET stereo 24-bit pairs and requests a
// data-island slot for them. On grant it freezes a snapshot of the pairs,
// their present bits and the IEC 60958 channel-status frame index for the
// audio sample packet formatter.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_EMPTY   | no pairs buffered
// ST_FILL    | 0 < count < SAMPLES_PER_PACKET, flush timer running
// ST_PENDING | packet_pending high, waiting for grant, flush timer frozen
module audio_sample_scheduler #(
  parameter int unsigned SAMPLES_PER_PACKET = 4,
  parameter int unsigned FLUSH_CYCLES       = 1024
) (
  input  logic         clk_pixel,
  input  logic         reset,
  input  logic [23:0]  audio_sample_l,
  input  logic [23:0]  audio_sample_r,
  input  logic         audio_sample_valid,
  output logic         audio_sample_ready,
  input  logic         packet_grant,
  output logic         packet_pending,
  output logic [7:0]   frame_counter,
  output logic [191:0] audio_sample_word,
  output logic [3:0]   audio_sample_word_present,
  output logic [2:0]   buffer_count
);

  typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_PENDING} state_t;

  localparam logic [2:0]  SPP        = 3'(SAMPLES_PER_PACKET);
  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYCLES - 1);

  state_t         state_q, state_d;
  logic [2:0]     count_q, count_d;
  logic [15:0]    timer_q, timer_d;
  logic [7:0]     block_q, block_d;
  logic [191:0]   buf_q, buf_d;
  logic           pending_q, pending_d;
  logic [7:0]     frame_q, frame_d;
  logic [191:0]   word_q, word_d;
  logic [3:0]     present_q, present_d;

  logic           ready;
  logic           accept;
  logic           take;
  logic [8:0]     block_sum;
  logic [2:0]     count_base;

  // A grant frees the whole buffer this cycle, so a pair can be accepted even when full.
  assign ready  = (count_q < SPP) || packet_grant;
  assign accept = audio_sample_valid && ready;
  assign take   = packet_grant && (count_q != 3'd0);

  // Next-state: snapshot on grant, append accepted pair, then pick the state.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    timer_d    = timer_q;
    block_d    = block_q;
    buf_d      = buf_q;
    frame_d    = frame_q;
    word_d     = word_q;
    present_d  = present_q;
    count_base = count_q;
    // 9-bit sum so 190+4 wraps to 2 instead of overflowing the 8-bit index.
    block_sum  = {1'b0, block_q} + {6'd0, count_q};

    if (take) begin
      word_d     = buf_q;
      present_d  = 4'((5'd1 << count_q) - 5'd1);
      frame_d    = block_q;
      block_d    = (block_sum >= 9'd192) ? 8'(block_sum - 9'd192) : block_sum[7:0];
      buf_d      = '0;
      count_base = 3'd0;
      timer_d    = '0;
    end

    count_d = count_base;
    if (accept) begin
      // The new pair goes after whatever survives the grant: slot 0 if the buffer was taken.
      for (int k = 0; k < 4; k++) begin
        if (count_base == 3'(k)) begin
          buf_d[48*k +: 48] = {audio_sample_r, audio_sample_l};
        end
      end
      count_d = count_base + 3'd1;
    end

    if (count_d == 3'd0) begin
      state_d = ST_EMPTY;
    end else if (count_d == SPP) begin
      state_d = ST_PENDING;
    end else if (take || (state_q == ST_EMPTY)) begin
      state_d = ST_FILL;
      timer_d = '0;
    end else if (state_q == ST_PENDING) begin
      state_d = ST_PENDING;
    end else if (timer_q == FLUSH_LAST) begin
      state_d = ST_PENDING;
    end else begin
      state_d = ST_FILL;
      timer_d = timer_q + 16'd1;
    end

    pending_d = (state_d == ST_PENDING);
  end

  // State and registered outputs, synchronous reset discards the buffer.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      count_q   <= '0;
      timer_q   <= '0;
      block_q   <= '0;
      buf_q     <= '0;
      pending_q <= 1'b0;
      frame_q   <= '0;
      word_q    <= '0;
      present_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      block_q   <= block_d;
      buf_q     <= buf_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      word_q    <= word_d;
      present_q <= present_d;
    end
  end

  assign audio_sample_ready        = ready;
  assign packet_pending            = pending_q;
  assign frame_counter             = frame_q;
  assign audio_sample_word         = word_q;
  assign audio_sample_word_present = present_q;
  assign buffer_count              = count_q;

endmodule
